// File: rtl/hdr_pair_aligner_pkg.sv
`default_nettype none
// =============================================================================
// hdr_pkg : shared types and constants for hdr_pair_aligner  (rev 1.0)
// =============================================================================
package hdr_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    ALIGN  = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Framing part of a stored entry; the full entry is {eop, sop, r, g, b}.
  typedef struct packed {
    logic eop;
    logic sop;
  } pix_ctl_t;

  function automatic int pix_width(input int dw);
    return 3 * dw + $bits(pix_ctl_t);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdr_pair_aligner_if.sv
`default_nettype none
// =============================================================================
// hdr_pair_aligner_if : two Avalon-ST sinks plus the paired source  (rev 1.0)
// =============================================================================
interface hdr_pair_aligner_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  asi_snk_0_valid_i;
  logic                  asi_snk_0_ready_o;
  logic [DATA_WIDTH-1:0] asi_snk_0_data_r_i;
  logic [DATA_WIDTH-1:0] asi_snk_0_data_g_i;
  logic [DATA_WIDTH-1:0] asi_snk_0_data_b_i;
  logic                  asi_snk_0_startofpacket_i;
  logic                  asi_snk_0_endofpacket_i;

  logic                  asi_snk_1_valid_i;
  logic                  asi_snk_1_ready_o;
  logic [DATA_WIDTH-1:0] asi_snk_1_data_r_i;
  logic [DATA_WIDTH-1:0] asi_snk_1_data_g_i;
  logic [DATA_WIDTH-1:0] asi_snk_1_data_b_i;
  logic                  asi_snk_1_startofpacket_i;
  logic                  asi_snk_1_endofpacket_i;

  logic                  aso_src_valid_o;
  logic                  aso_src_startofpacket_o;
  logic                  aso_src_endofpacket_o;
  logic [DATA_WIDTH-1:0] aso_src_0_data_r_o;
  logic [DATA_WIDTH-1:0] aso_src_0_data_g_o;
  logic [DATA_WIDTH-1:0] aso_src_0_data_b_o;
  logic [DATA_WIDTH-1:0] aso_src_1_data_r_o;
  logic [DATA_WIDTH-1:0] aso_src_1_data_g_o;
  logic [DATA_WIDTH-1:0] aso_src_1_data_b_o;

  modport master (
    output asi_snk_0_valid_i, asi_snk_0_data_r_i, asi_snk_0_data_g_i, asi_snk_0_data_b_i,
    output asi_snk_0_startofpacket_i, asi_snk_0_endofpacket_i,
    input  asi_snk_0_ready_o,
    output asi_snk_1_valid_i, asi_snk_1_data_r_i, asi_snk_1_data_g_i, asi_snk_1_data_b_i,
    output asi_snk_1_startofpacket_i, asi_snk_1_endofpacket_i,
    input  asi_snk_1_ready_o,
    input  aso_src_valid_o, aso_src_startofpacket_o, aso_src_endofpacket_o,
    input  aso_src_0_data_r_o, aso_src_0_data_g_o, aso_src_0_data_b_o,
    input  aso_src_1_data_r_o, aso_src_1_data_g_o, aso_src_1_data_b_o
  );

  modport slave (
    input  asi_snk_0_valid_i, asi_snk_0_data_r_i, asi_snk_0_data_g_i, asi_snk_0_data_b_i,
    input  asi_snk_0_startofpacket_i, asi_snk_0_endofpacket_i,
    output asi_snk_0_ready_o,
    input  asi_snk_1_valid_i, asi_snk_1_data_r_i, asi_snk_1_data_g_i, asi_snk_1_data_b_i,
    input  asi_snk_1_startofpacket_i, asi_snk_1_endofpacket_i,
    output asi_snk_1_ready_o,
    output aso_src_valid_o, aso_src_startofpacket_o, aso_src_endofpacket_o,
    output aso_src_0_data_r_o, aso_src_0_data_g_o, aso_src_0_data_b_o,
    output aso_src_1_data_r_o, aso_src_1_data_g_o, aso_src_1_data_b_o
  );

endinterface
`default_nettype wire

// File: rtl/hdr_pair_aligner_pix_fifo.sv
`default_nettype none
// =============================================================================
// pix_fifo : synchronous FIFO with registered ready, async active-low reset  (rev 1.0)
// =============================================================================
module pix_fifo #(
  parameter int DATA_WIDTH = 98,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  ready_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic [AW:0]           count_d;
  logic                  ready_q;
  logic                  push;
  logic                  pop;

  assign push = wr_valid_i && ready_q;
  assign pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Ready looks at next occupancy so a full FIFO drops ready on the filling edge.
      ready_q <= (count_d < DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign ready_o = ready_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/hdr_pair_aligner.sv
`default_nettype none
// =============================================================================
// hdr_pair_aligner : aligns two exposure streams on sop into one paired stream  (rev 1.0)
// Optional frame/error counters with `define HDR_PAIR_STATS_EN.
// =============================================================================
module hdr_pair_aligner
  import hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hdr_pair_aligner_if.slave bus,
  output logic              err_o
`ifdef HDR_PAIR_STATS_EN
  ,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
`endif
);

  localparam int ENTRY_W = pix_width(DATA_WIDTH);

  typedef struct packed {
    pix_ctl_t              ctl;
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
  } pix_t;

  pix_t   wr0, wr1, head0, head1;
  logic   empty0, empty1;
  logic   rdy0, rdy1;
  logic   pop0, pop1;
  logic   both_v;
  logic   emit, sop_d, eop_d, err_d;
  state_e state_q, state_d;

  logic                  valid_q, sop_q, eop_q, err_q;
  logic [DATA_WIDTH-1:0] r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;

  assign wr0 = {bus.asi_snk_0_endofpacket_i, bus.asi_snk_0_startofpacket_i,
                bus.asi_snk_0_data_r_i, bus.asi_snk_0_data_g_i, bus.asi_snk_0_data_b_i};
  assign wr1 = {bus.asi_snk_1_endofpacket_i, bus.asi_snk_1_startofpacket_i,
                bus.asi_snk_1_data_r_i, bus.asi_snk_1_data_g_i, bus.asi_snk_1_data_b_i};

  pix_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid_i (bus.asi_snk_0_valid_i),
    .wr_data_i  (wr0),
    .ready_o    (rdy0),
    .pop_i      (pop0),
    .head_o     (head0),
    .empty_o    (empty0)
  );

  pix_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid_i (bus.asi_snk_1_valid_i),
    .wr_data_i  (wr1),
    .ready_o    (rdy1),
    .pop_i      (pop1),
    .head_o     (head1),
    .empty_o    (empty1)
  );

  assign bus.asi_snk_0_ready_o = rdy0;
  assign bus.asi_snk_1_ready_o = rdy1;
  assign both_v = !empty0 && !empty1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ALIGN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALIGN: begin
        if (both_v && head0.ctl.sop && head1.ctl.sop && !(head0.ctl.eop && head1.ctl.eop))
          state_d = STREAM;
      end
      STREAM: begin
        if (both_v && (head0.ctl.sop || head1.ctl.sop || head0.ctl.eop || head1.ctl.eop))
          state_d = ALIGN;
      end
      default: state_d = ALIGN;
    endcase
  end

  always_comb begin
    pop0  = 1'b0;
    pop1  = 1'b0;
    emit  = 1'b0;
    sop_d = 1'b0;
    eop_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      ALIGN: begin
        if (both_v && head0.ctl.sop && head1.ctl.sop) begin
          pop0  = 1'b1;
          pop1  = 1'b1;
          emit  = 1'b1;
          sop_d = 1'b1;
          eop_d = head0.ctl.eop && head1.ctl.eop;
        end else begin
          // Each side independently drops beats until it reaches a frame start.
          pop0 = !empty0 && !head0.ctl.sop;
          pop1 = !empty1 && !head1.ctl.sop;
        end
      end
      STREAM: begin
        if (both_v) begin
          if (head0.ctl.sop || head1.ctl.sop) begin
            err_d = 1'b1;
          end else begin
            pop0  = 1'b1;
            pop1  = 1'b1;
            emit  = 1'b1;
            eop_d = head0.ctl.eop || head1.ctl.eop;
            err_d = head0.ctl.eop ^ head1.ctl.eop;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      r0_q    <= '0;
      g0_q    <= '0;
      b0_q    <= '0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
    end else begin
      valid_q <= emit;
      sop_q   <= emit && sop_d;
      eop_q   <= emit && eop_d;
      err_q   <= err_d;
      r0_q    <= emit ? head0.r : '0;
      g0_q    <= emit ? head0.g : '0;
      b0_q    <= emit ? head0.b : '0;
      r1_q    <= emit ? head1.r : '0;
      g1_q    <= emit ? head1.g : '0;
      b1_q    <= emit ? head1.b : '0;
    end
  end

  assign bus.aso_src_valid_o         = valid_q;
  assign bus.aso_src_startofpacket_o = sop_q;
  assign bus.aso_src_endofpacket_o   = eop_q;
  assign bus.aso_src_0_data_r_o      = r0_q;
  assign bus.aso_src_0_data_g_o      = g0_q;
  assign bus.aso_src_0_data_b_o      = b0_q;
  assign bus.aso_src_1_data_r_o      = r1_q;
  assign bus.aso_src_1_data_g_o      = g1_q;
  assign bus.aso_src_1_data_b_o      = b1_q;
  assign err_o                       = err_q;

`ifdef HDR_PAIR_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (emit && eop_d) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (err_d)         err_cnt_q   <= err_cnt_q + 1'b1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`endif

endmodule
`default_nettype wire
